// File: rtl/seg_pkg.sv
// Shared types and constants for the paged 7-segment display scheduler.
package seg_pkg;

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, CONVERT, COMMIT, DWELL} state_t;

  localparam int unsigned BCD_MAX = 9999;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned N_CH    = 3;

  // Round-robin pick: cur+1, then cur+2 (mod 3), falling back to cur itself.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [N_CH-1:0] en);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (en[c1])      next_ch = c1;
    else if (en[c2]) next_ch = c2;
    else             next_ch = cur;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter, one bit per cycle.
module bin2bcd_seq #(
  parameter int unsigned W = 14
) (
  input  logic         clk_50MHZ,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         done,
  output logic [15:0]  bcd
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic [15:0]   adj;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= CW'(W);
    end else if (cnt != '0) begin
      bcd <= {adj[14:0], sh[W-1]};
      sh  <= sh << 1;
      cnt <= cnt - 1'b1;
    end
  end

  // High during the final iteration, so bcd is complete on the following cycle.
  assign done = (cnt == CW'(1));

endmodule

// File: rtl/seg_page_sched.sv
// Round-robin pager: shows three binary channels as saturated decimal digits,
// refreshing the current page on every tick and rotating after a dwell time.
module seg_page_sched import seg_pkg::*; #(
  parameter int unsigned W           = 14,
  parameter int unsigned TICK_DIV    = 5_000_000,
  parameter int unsigned DWELL_TICKS = 20
) (
  input  logic             clk_50MHZ,
  input  logic             rst_n,
  input  logic [W-1:0]     val_0,
  input  logic [W-1:0]     val_1,
  input  logic [W-1:0]     val_2,
  input  logic [N_CH-1:0]  en,
  input  logic             hold,
  output logic [DIG_W-1:0] dig_1,
  output logic [DIG_W-1:0] dig_2,
  output logic [DIG_W-1:0] dig_3,
  output logic [DIG_W-1:0] dig_4,
  output logic [1:0]       page,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [1:0]    sel, sel_nxt;
  logic          pend_ovf, pend_ovf_nxt;
  logic [W-1:0]  raw, bin_sat;
  logic          sat;
  logic          conv_start, conv_done;
  logic [15:0]   bcd;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_50MHZ or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  always_comb begin
    case (sel)
      2'd0:    raw = val_0;
      2'd1:    raw = val_1;
      default: raw = val_2;
    endcase
    sat     = (32'(raw) > BCD_MAX);
    bin_sat = sat ? W'(BCD_MAX) : raw;
  end

  assign conv_start = (state == LOAD);
  assign busy       = (state == LOAD) || (state == CONVERT) || (state == COMMIT);

  bin2bcd_seq #(.W(W)) u_bin2bcd (
    .clk_50MHZ (clk_50MHZ),
    .rst_n     (rst_n),
    .start     (conv_start),
    .bin       (bin_sat),
    .done      (conv_done),
    .bcd       (bcd)
  );

  always_comb begin
    state_nxt    = state;
    dwell_nxt    = dwell;
    sel_nxt      = sel;
    pend_ovf_nxt = pend_ovf;
    case (state)
      IDLE:    if (en != '0) state_nxt = SELECT;
      SELECT: begin
        dwell_nxt = '0;
        if (en == '0) begin
          state_nxt = IDLE;
        end else begin
          sel_nxt   = next_ch(page, en);
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        pend_ovf_nxt = sat;
        state_nxt    = CONVERT;
      end
      CONVERT: if (conv_done) state_nxt = COMMIT;
      COMMIT:  state_nxt = DWELL;
      DWELL: begin
        // A dropped channel pre-empts any tick arriving in the same cycle.
        if (!en[page]) begin
          state_nxt = SELECT;
        end else if (tick) begin
          if (dwell == DW'(DWELL_TICKS - 1) && !hold) begin
            state_nxt = SELECT;
          end else begin
            if (dwell != DW'(DWELL_TICKS - 1)) dwell_nxt = dwell + 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dwell    <= '0;
      sel      <= '0;
      pend_ovf <= 1'b0;
      dig_1    <= '0;
      dig_2    <= '0;
      dig_3    <= '0;
      dig_4    <= '0;
      page     <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      dwell    <= dwell_nxt;
      sel      <= sel_nxt;
      pend_ovf <= pend_ovf_nxt;
      if (state == COMMIT) begin
        dig_1 <= bcd[3:0];
        dig_2 <= bcd[7:4];
        dig_3 <= bcd[11:8];
        dig_4 <= bcd[15:12];
        page  <= sel;
        ovf   <= pend_ovf;
      end
    end
  end

endmodule

// File: tb/tb_seg_page_sched.sv
// Randomized self-checking bench for seg_page_sched against a decimal/round-robin reference.
module tb_seg_page_sched;

  localparam int unsigned W           = 14;
  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned DWELL_TICKS = 3;

  logic         clk_50MHZ = 1'b0;
  logic         rst_n     = 1'b0;
  logic [W-1:0] val_0     = '0;
  logic [W-1:0] val_1     = '0;
  logic [W-1:0] val_2     = '0;
  logic [2:0]   en        = '0;
  logic         hold      = 1'b0;
  logic [3:0]   dig_1, dig_2, dig_3, dig_4;
  logic [1:0]   page;
  logic         ovf, busy;

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc;

  seg_page_sched #(.W(W), .TICK_DIV(TICK_DIV), .DWELL_TICKS(DWELL_TICKS)) dut (
    .clk_50MHZ (clk_50MHZ),
    .rst_n     (rst_n),
    .val_0     (val_0),
    .val_1     (val_1),
    .val_2     (val_2),
    .en        (en),
    .hold      (hold),
    .dig_1     (dig_1),
    .dig_2     (dig_2),
    .dig_3     (dig_3),
    .dig_4     (dig_4),
    .page      (page),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #10 clk_50MHZ = ~clk_50MHZ;

  // Cycles since reset release; a tick is pending whenever cyc % TICK_DIV == TICK_DIV-1.
  always @(posedge clk_50MHZ or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [15:0] exp_bcd(input int unsigned v);
    int unsigned s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic int unsigned exp_next(input int unsigned p, input logic [2:0] e);
    for (int unsigned k = 1; k <= 3; k++) begin
      if (e[(p + k) % 3]) return (p + k) % 3;
    end
    return p;
  endfunction

  function automatic int unsigned val_of(input int unsigned p);
    case (p)
      0:       return int'(val_0);
      1:       return int'(val_1);
      default: return int'(val_2);
    endcase
  endfunction

  function automatic logic [15:0] shown();
    return {dig_4, dig_3, dig_2, dig_1};
  endfunction

  // Waits for busy to rise (unless already high) and then fall; blen counts busy cycles seen.
  task automatic wait_commit(output int unsigned blen, output bit ok);
    int unsigned n;
    ok = 1'b0;
    blen = 0;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clk_50MHZ);
      n++;
    end
    if (busy !== 1'b1) return;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk_50MHZ);
      blen++;
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    int unsigned bl, n;
    bit ok, busy_seen;
    rst_n = 1'b0;
    en    = 3'b001;
    val_0 = 14'd1234;
    repeat (3) @(negedge clk_50MHZ);
    rst_n = 1'b1;
    wait_commit(bl, ok);
    n_chk++;
    if (!ok || shown() !== 16'h1234) begin
      n_fail++;
      $display("FAIL reset_precommit ok=%0d digits=%h expected 1234", ok, shown());
    end
    n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge clk_50MHZ);
      n++;
    end
    repeat (6) @(negedge clk_50MHZ);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midconv_busy got %b expected 1", busy);
    end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (shown() !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_digits got %h expected 0000", shown());
    end
    n_chk++;
    if (page !== 2'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags page=%0d ovf=%b busy=%b expected 0 0 0", page, ovf, busy);
    end
    en = 3'b000;
    @(negedge clk_50MHZ);
    #2 rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk_50MHZ);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    n_chk++;
    if (busy_seen || shown() !== 16'h0000 || page !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idle busy_seen=%0d digits=%h page=%0d expected 0 0000 0", busy_seen, shown(), page);
    end
  endtask

  task automatic test_convert();
    int unsigned bl;
    bit ok;
    int unsigned vals[$];
    en    = 3'b001;
    val_0 = 14'd1234;
    wait_commit(bl, ok);
    n_chk++;
    if (!ok || bl != W + 2) begin
      n_fail++;
      $display("FAIL conv_busy_len ok=%0d len=%0d expected %0d", ok, bl, W + 2);
    end
    n_chk++;
    if (shown() !== 16'h1234 || page !== 2'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_1234 digits=%h page=%0d ovf=%b expected 1234 0 0", shown(), page, ovf);
    end
    val_0 = 14'd42;
    wait_commit(bl, ok);
    n_chk++;
    if (!ok || shown() !== 16'h0042) begin
      n_fail++;
      $display("FAIL conv_0042 ok=%0d digits=%h expected 0042", ok, shown());
    end
    // Input change mid-conversion must not leak into the committed value.
    while (busy !== 1'b1 && bl < 400) begin
      @(negedge clk_50MHZ);
      bl++;
    end
    repeat (3) @(negedge clk_50MHZ);
    val_0 = 14'd7777;
    wait_commit(bl, ok);
    n_chk++;
    if (!ok || shown() !== 16'h0042) begin
      n_fail++;
      $display("FAIL conv_snapshot ok=%0d digits=%h expected 0042", ok, shown());
    end
    wait_commit(bl, ok);
    n_chk++;
    if (!ok || shown() !== 16'h7777) begin
      n_fail++;
      $display("FAIL conv_7777 ok=%0d digits=%h expected 7777", ok, shown());
    end
    vals = '{12000, 9999, 10000, 0, 16383};
    repeat (8) vals.push_back($urandom_range(0, 16383));
    foreach (vals[i]) begin
      val_0 = W'(vals[i]);
      wait_commit(bl, ok);
      n_chk++;
      if (!ok || shown() !== exp_bcd(vals[i]) || ovf !== (vals[i] > 9999)) begin
        n_fail++;
        $display("FAIL conv_value v=%0d ok=%0d digits=%h ovf=%b expected %h %b",
                 vals[i], ok, shown(), ovf, exp_bcd(vals[i]), vals[i] > 9999);
      end
    end
  endtask

  task automatic test_rotate();
    int unsigned bl, prev, pg, run, changes;
    bit ok;
    val_0 = 14'd7;
    val_1 = 14'd4321;
    val_2 = 14'd5678;
    en    = 3'b101;
    prev    = page;
    run     = 0;
    changes = 0;
    for (int i = 0; i < 14; i++) begin
      wait_commit(bl, ok);
      pg = page;
      n_chk++;
      if (!ok || pg == 1) begin
        n_fail++;
        $display("FAIL rot_commit i=%0d ok=%0d page=%0d expected page 0 or 2", i, ok, pg);
      end
      if (pg != prev) begin
        n_chk++;
        if (pg != exp_next(prev, en)) begin
          n_fail++;
          $display("FAIL rot_order got page %0d expected %0d", pg, exp_next(prev, en));
        end
        if (changes > 0) begin
          n_chk++;
          if (run != DWELL_TICKS) begin
            n_fail++;
            $display("FAIL rot_dwell page %0d shown for %0d refreshes expected %0d", prev, run, DWELL_TICKS);
          end
        end
        changes++;
        run  = 1;
        prev = pg;
      end else begin
        run++;
      end
      n_chk++;
      if (shown() !== exp_bcd(val_of(pg)) || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL rot_digits page=%0d digits=%h ovf=%b expected %h 0", pg, shown(), ovf, exp_bcd(val_of(pg)));
      end
    end
    n_chk++;
    if (changes < 3) begin
      n_fail++;
      $display("FAIL rot_changes got %0d page changes expected at least 3", changes);
    end
  endtask

  task automatic test_hold();
    int unsigned bl, n, v;
    bit ok;
    en = 3'b111;
    val_1 = 14'd1111;
    n = 0;
    do begin
      wait_commit(bl, ok);
      n++;
    end while (page !== 2'd1 && n < 12);
    n_chk++;
    if (page !== 2'd1) begin
      n_fail++;
      $display("FAIL hold_reach got page %0d expected 1", page);
    end
    hold = 1'b1;
    for (int i = 0; i < 11; i++) begin
      v = $urandom_range(0, 16383);
      val_1 = W'(v);
      wait_commit(bl, ok);
      n_chk++;
      if (!ok || page !== 2'd1 || shown() !== exp_bcd(v) || ovf !== (v > 9999)) begin
        n_fail++;
        $display("FAIL hold_track i=%0d ok=%0d page=%0d digits=%h ovf=%b expected 1 %h %b",
                 i, ok, page, shown(), ovf, exp_bcd(v), v > 9999);
      end
    end
    hold = 1'b0;
    wait_commit(bl, ok);
    n_chk++;
    if (!ok || page !== 2'd2 || shown() !== exp_bcd(val_of(2))) begin
      n_fail++;
      $display("FAIL hold_release ok=%0d page=%0d digits=%h expected 2 %h", ok, page, shown(), exp_bcd(val_of(2)));
    end
  endtask

  task automatic test_drop();
    int unsigned bl, n;
    bit ok, busy_seen;
    logic b_sel, b_load;
    n = 0;
    while ((cyc % TICK_DIV) != TICK_DIV - 1 && n < 8) begin
      @(negedge clk_50MHZ);
      n++;
    end
    n_chk++;
    if (busy !== 1'b0 || page !== 2'd2) begin
      n_fail++;
      $display("FAIL drop_pre busy=%b page=%0d expected 0 2", busy, page);
    end
    en = 3'b011;
    @(negedge clk_50MHZ);
    b_sel = busy;
    @(negedge clk_50MHZ);
    b_load = busy;
    n_chk++;
    if (b_sel !== 1'b0 || b_load !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_select busy seq=%b%b expected 01", b_sel, b_load);
    end
    wait_commit(bl, ok);
    n_chk++;
    if (!ok || page !== 2'd0 || shown() !== exp_bcd(val_of(0))) begin
      n_fail++;
      $display("FAIL drop_page ok=%0d page=%0d digits=%h expected 0 %h", ok, page, shown(), exp_bcd(val_of(0)));
    end
    en = 3'b000;
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk_50MHZ);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    n_chk++;
    if (busy_seen || page !== 2'd0 || shown() !== exp_bcd(val_of(0))) begin
      n_fail++;
      $display("FAIL drop_idle busy_seen=%0d page=%0d digits=%h expected 0 0 %h",
               busy_seen, page, shown(), exp_bcd(val_of(0)));
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_rotate();
    test_hold();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_page_sched.md
Name: seg_page_sched

Overview:
- Display scheduler that feeds the 4-digit 7-segment scan driver (digit inputs in_1..in_4, values 0-9).
- Three binary channels share the one display, round-robin.
- Each page is shown for a programmable dwell time and refreshed live on every tick.
- Binary-to-BCD conversion is sequential (shift-add-3), so no wide combinational divider is needed.

Parameters:
- W, 14: width of each channel value (max 16383).
- TICK_DIV, 5_000_000: clk_50MHZ cycles per tick (100 ms); must be >= 2.
- DWELL_TICKS, 20: ticks per page (2 s); must be >= 1.

Ports:
- clk_50MHZ  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- val_0  in  W  channel 0 binary value.
- val_1  in  W  channel 1 binary value.
- val_2  in  W  channel 2 binary value.
- en  in  3  channel enables; bit i enables val_i.
- hold  in  1  freeze rotation on the current page.
- dig_1  out  4  ones digit, drives the scan driver's in_1 (rightmost).
- dig_2  out  4  tens digit, drives in_2.
- dig_3  out  4  hundreds digit, drives in_3.
- dig_4  out  4  thousands digit, drives in_4.
- page  out  2  channel currently displayed (0..2).
- ovf  out  1  displayed value was saturated.
- busy  out  1  conversion in progress (LOAD/CONVERT/COMMIT).

Behaviour:
- Reset (async, rst_n=0):
  - dig_1..dig_4=0, page=0, ovf=0, busy=0.
  - State IDLE, tick counter 0, dwell counter 0.
  - Reset mid-conversion abandons it; outputs go to reset values immediately.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; produces a 1-cycle tick pulse when it wraps.
  - Independent of FSM state.
  - Ticks arriving outside DWELL are dropped.
- FSM states:
  - IDLE: if en!=0, go to SELECT; otherwise stay. Outputs hold their last committed values.
  - SELECT (1 cycle):
    - Picks the next enabled channel after the current page, searching page+1, page+2, page, wrapping 2->0.
    - If the only enabled channel is the current page, it is reselected.
    - Clears the dwell counter.
    - If en==0, goes to IDLE.
  - LOAD (1 cycle):
    - Snapshots val_<sel>; later input changes are ignored until the next LOAD.
    - If the snapshot is > 9999, it is replaced by 9999 and a pending-ovf flag is set.
    - Clears the BCD shift register.
  - CONVERT:
    - Exactly W cycles, one shift-add-3 iteration per cycle.
    - On each digit >= 5, add 3 before the shift.
  - COMMIT (1 cycle):
    - Registers dig_1..dig_4, page=sel, and ovf=pending flag.
    - Goes to DWELL.
  - DWELL:
    - On tick with dwell counter = DWELL_TICKS-1 and hold=0: go to SELECT.
    - On any other tick: dwell counter += 1 (saturating while hold=1), then go to LOAD of the same channel (live refresh).
- Fixed latency: outputs change exactly W+2 cycles after entering LOAD (16 cycles at W=14).
- busy=1 in LOAD, CONVERT and COMMIT; otherwise 0.
- Channel drop: if en[page] deasserts in DWELL, go to SELECT next cycle without waiting for a tick. If all en=0, SELECT goes to IDLE and digits hold.
- en changes during LOAD/CONVERT/COMMIT take effect at the next DWELL check.
- Simultaneous tick and en[page] drop in DWELL: the drop wins (go to SELECT).
- hold=1: rotation frozen; refresh still occurs every tick.
- Digits are always 0..9, so the scan driver's default decode branch is never exercised.

Decomposition:
- Shared package seg_pkg holds:
  - state encoding constants: IDLE, SELECT, LOAD, CONVERT, COMMIT, DWELL;
  - BCD_MAX=9999;
  - digit width 4;
  - number of channels 3.
- One natural sub-module, bin2bcd_seq:
  - Interface: start, bin[W-1:0], done, bcd[15:0].
  - Contains the W-cycle shift-add-3 engine and its iteration counter.
  - Saturation is handled in the parent.
  - The parent holds the FSM, tick/dwell counters and round-robin select.

Test Plan (bench uses TICK_DIV=4, DWELL_TICKS=3):
1. Reset: assert rst_n=0 mid-CONVERT -> dig_1..dig_4=0, page=0, ovf=0, busy=0 immediately. Release with en=0 -> state stays IDLE, outputs unchanged.
2. en=3'b001, val_0=1234 -> 16 cycles after LOAD: dig_4..dig_1=1,2,3,4, page=0, ovf=0, busy high for exactly 16 cycles. Change val_0 to 0042 -> next refresh shows 0,0,4,2.
3. en=3'b001, val_0=12000 -> digits 9,9,9,9, ovf=1. val_0=9999 -> 9,9,9,9 with ovf=0. val_0=0 -> 0,0,0,0.
4. en=3'b101, val_0=7, val_2=5678 -> page sequence 0,2,0,2, each page held for 3 ticks (12 cycles plus conversion). Channel 1 is never shown.
5. en=3'b111 on page 1 with hold=1 -> page stays 1 across 10 ticks and digits track val_1. Release hold -> page 2 after the next dwell expiry.
6. On page 2 in DWELL, drop en to 3'b011 coincident with a tick -> SELECT next cycle, page=0 after the conversion. Then en=0 -> IDLE, digits hold the last value.
